// File: rtl/axis_rr_arbiter.sv
// Packet-aware round-robin AXI-Stream arbiter with a registered output stage.
// Build option: define AXIS_ARB_PRIO0_EN to give input 0 strict priority.
module axis_rr_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_INPUTS = 4,
  localparam int ID_WIDTH = $clog2(NUM_INPUTS)
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_INPUTS-1:0]            s_axis_tvalid,
  input  logic [NUM_INPUTS-1:0]            s_axis_tlast,
  output logic [NUM_INPUTS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic                             m_axis_tvalid,
  output logic                             m_axis_tlast,
  output logic [ID_WIDTH-1:0]              m_axis_tid,
  input  logic                             m_axis_tready
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t                state;
  state_t                state_n;
  logic [ID_WIDTH-1:0]   grant_idx;
  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [ID_WIDTH-1:0]   pick;
  logic [ID_WIDTH-1:0]   ptr_n;
  logic                  found;
  logic                  out_free;
  logic                  hs;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_last;

  assign out_free = !m_axis_tvalid || m_axis_tready;
  assign sel_data = s_axis_tdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
  assign sel_last = s_axis_tlast[grant_idx];
  assign hs       = (state == LOCKED) && s_axis_tvalid[grant_idx]
                    && out_free;
  assign ptr_n    = (grant_idx == ID_WIDTH'(NUM_INPUTS-1))
                    ? '0 : grant_idx + 1'b1;

  // Arbitration: first valid input at or after rr_ptr, wrapping.
  always_comb begin
    logic [ID_WIDTH-1:0] idx;
    pick  = '0;
    found = 1'b0;
    idx   = '0;
`ifdef AXIS_ARB_PRIO0_EN
    if (s_axis_tvalid[0]) begin
      pick  = '0;
      found = 1'b1;
    end
`endif
    for (int k = 0; k < NUM_INPUTS; k++) begin
      idx = ID_WIDTH'((int'(rr_ptr) + k) % NUM_INPUTS);
`ifdef AXIS_ARB_PRIO0_EN
      if (!found && s_axis_tvalid[idx] && idx != '0) begin
`else
      if (!found && s_axis_tvalid[idx]) begin
`endif
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge aclk) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_n;
  end

  // Next-state logic: lock on a grant, release on the tlast handshake.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (found)         state_n = LOCKED;
      LOCKED:  if (hs && sel_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output logic: only the granted input sees ready.
  always_comb begin
    s_axis_tready = '0;
    if (state == LOCKED) s_axis_tready[grant_idx] = out_free;
  end

  // Grant index and round-robin pointer.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      grant_idx <= '0;
      rr_ptr    <= '0;
    end else if (state == IDLE) begin
      if (found) grant_idx <= pick;
    end else if (hs && sel_last) begin
`ifdef AXIS_ARB_PRIO0_EN
      if (grant_idx != '0) rr_ptr <= ptr_n;
`else
      rr_ptr <= ptr_n;
`endif
    end
  end

  // Output register: load on slave handshake, drain on downstream ready.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tid    <= '0;
    end else if (hs) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= sel_data;
      m_axis_tlast  <= sel_last;
      m_axis_tid    <= grant_idx;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule
